spi_rom_sched: RTL and testbench

Two-requester scheduler and sequencer for the shared SPI flash ROM. It arbitrates read requests from the video line fetcher (channel 0) and an auxiliary fetcher (channel 1). For each grant it runs one complete READ (03h) transaction: command, 24-bit address, then N data bytes. Bytes return as a tagged stream. It sits between the fetch engines and the SPI pins, replacing per-fetcher direct pin control.

---
 rtl/spi_rom_pkg.sv | 18 +
 rtl/spi_rom_rr_arb.sv | 40 ++++
 rtl/spi_rom_sched.sv | 169 ++++++++++++++++
 tb/tb_spi_rom_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_rom_pkg.sv
// Shared types and constants for the SPI flash ROM scheduler.
// Contents: sequencer state enum, READ command opcode, address and preamble lengths.
package spi_rom_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StAddr,
      StData,
      StGap
   } state_e;

   localparam logic [7:0]  SPI_CMD_READ = 8'h03;
   localparam int unsigned SPI_ADDR_LEN = 24;
   // Command byte plus 24-bit address, shifted out as one word.
   localparam int unsigned PREAMBLE_LEN = 32;

endpackage

// File: rtl/spi_rom_rr_arb.sv
// Two-way round-robin arbiter with a last-grant pointer.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   req[1:0]     : request per channel
//   en           : grants are only issued while en is high
//   gnt[1:0]     : one-hot combinational grant
//   gnt_ch       : index of the granted channel (0 when nothing is granted)
module spi_rom_rr_arb
   import spi_rom_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt,
   output logic       gnt_ch
);

   logic last_q;

   always_comb begin
      gnt    = 2'b00;
      gnt_ch = 1'b0;
      if (en && (req != 2'b00)) begin
         // On a tie the channel that was not granted last wins.
         gnt_ch = (req == 2'b11) ? ~last_q : req[1];
         gnt    = gnt_ch ? 2'b10 : 2'b01;
      end
   end

   // Pointer starts at 1 so channel 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_q <= 1'b1;
      end else if (gnt != 2'b00) begin
         last_q <= gnt_ch;
      end
   end

endmodule

// File: rtl/spi_rom_sched.sv
// Scheduler and sequencer for the shared SPI flash ROM. Arbitrates two fetch
// channels and runs one READ transaction (command, 24-bit address, N bytes) per grant.
// Ports:
//   clk, reset_n           : clock, synchronous active-low reset
//   chN_req/addr/len       : request, start address, byte count (0 = 256)
//   chN_ack, chN_done      : grant pulse, last-byte pulse
//   rd_data/rd_valid/rd_ch : tagged received byte stream
//   busy                   : sequencer not idle
//   spi_cs (active high), spi_sclk (= ~clk), spi_mosi, spi_miso : flash pins
module spi_rom_sched
   import spi_rom_pkg::*;
#(
   parameter logic [7:0]  SPI_CMD    = SPI_CMD_READ,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ch0_req,
   input  logic [23:0] ch0_addr,
   input  logic [7:0]  ch0_len,
   output logic        ch0_ack,
   output logic        ch0_done,
   input  logic        ch1_req,
   input  logic [23:0] ch1_addr,
   input  logic [7:0]  ch1_len,
   output logic        ch1_ack,
   output logic        ch1_done,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   output logic        rd_ch,
   output logic        busy,
   output logic        spi_cs,
   output logic        spi_sclk,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   state_e                  state_q, state_d;
   logic [8:0]              bit_cnt_q;
   logic [8:0]              bytes_left_q;
   logic [PREAMBLE_LEN-1:0] pre_sreg_q;
   logic [6:0]              byte_sreg_q;
   logic                    ch_q;
   logic                    miso_q;
   logic [7:0]              rd_data_q;
   logic                    rd_valid_q, rd_ch_q, done0_q, done1_q;

   logic [1:0] gnt;
   logic       gnt_ch, grant_en;
   logic       phase_end, byte_end;
   logic [7:0] len_sel;

   spi_rom_rr_arb u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req     ({ch1_req, ch0_req}),
      .en      (grant_en),
      .gnt     (gnt),
      .gnt_ch  (gnt_ch)
   );

   assign spi_sclk = ~clk;

   // Only negedge flop: samples MISO on the rising edge of spi_sclk.
   always_ff @(negedge clk) begin
      if (!reset_n) begin
         miso_q <= 1'b0;
      end else begin
         miso_q <= spi_miso;
      end
   end

   // Bit counter wraps freely in DATA; only its low 3 bits matter there.
   always_comb begin
      byte_end  = (state_q == StData) && (bit_cnt_q[2:0] == 3'd7);
      phase_end = 1'b0;
      case (state_q)
         StCmd:   phase_end = (bit_cnt_q == 9'd7);
         StAddr:  phase_end = (bit_cnt_q == 9'(SPI_ADDR_LEN - 1));
         StData:  phase_end = byte_end && (bytes_left_q == 9'd1);
         StGap:   phase_end = (bit_cnt_q == 9'(GAP_CYCLES - 1));
         default: phase_end = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (gnt != 2'b00) state_d = StCmd;
         StCmd:   if (phase_end) state_d = StAddr;
         StAddr:  if (phase_end) state_d = StData;
         StData:  if (phase_end) state_d = StGap;
         StGap:   if (phase_end) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output logic.
   always_comb begin
      busy     = (state_q != StIdle);
      spi_cs   = (state_q == StCmd) || (state_q == StAddr) || (state_q == StData);
      spi_mosi = ((state_q == StCmd) || (state_q == StAddr)) ? pre_sreg_q[PREAMBLE_LEN-1] : 1'b0;
      // Gating with reset_n keeps a grant from pulsing while the state cannot advance.
      grant_en = (state_q == StIdle) && reset_n;
      ch0_ack  = gnt[0];
      ch1_ack  = gnt[1];
      rd_data  = rd_data_q;
      rd_valid = rd_valid_q;
      rd_ch    = rd_ch_q;
      ch0_done = done0_q;
      ch1_done = done1_q;
   end

   assign len_sel = gnt_ch ? ch1_len : ch0_len;

   // Datapath: counters, shifters and registered byte stream.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bit_cnt_q    <= '0;
         bytes_left_q <= '0;
         pre_sreg_q   <= '0;
         byte_sreg_q  <= '0;
         ch_q         <= 1'b0;
         rd_data_q    <= '0;
         rd_valid_q   <= 1'b0;
         rd_ch_q      <= 1'b0;
         done0_q      <= 1'b0;
         done1_q      <= 1'b0;
      end else begin
         if (state_d != state_q) begin
            bit_cnt_q <= '0;
         end else if (state_q != StIdle) begin
            bit_cnt_q <= bit_cnt_q + 9'd1;
         end

         if (gnt != 2'b00) begin
            pre_sreg_q   <= {SPI_CMD, gnt_ch ? ch1_addr : ch0_addr};
            bytes_left_q <= (len_sel == 8'd0) ? 9'd256 : {1'b0, len_sel};
            ch_q         <= gnt_ch;
         end else if ((state_q == StCmd) || (state_q == StAddr)) begin
            pre_sreg_q <= {pre_sreg_q[PREAMBLE_LEN-2:0], 1'b0};
         end

         if (state_q == StData) begin
            byte_sreg_q <= {byte_sreg_q[5:0], miso_q};
         end
         if (byte_end) begin
            bytes_left_q <= bytes_left_q - 9'd1;
            rd_data_q    <= {byte_sreg_q, miso_q};
            rd_ch_q      <= ch_q;
         end

         rd_valid_q <= byte_end;
         done0_q    <= byte_end && (bytes_left_q == 9'd1) && !ch_q;
         done1_q    <= byte_end && (bytes_left_q == 9'd1) && ch_q;
      end
   end

endmodule

// File: tb/tb_spi_rom_sched.sv
// Self-checking bench for spi_rom_sched: a behavioural SPI flash drives MISO,
// per-cycle pin expectations are derived from the transaction timing rules.
module tb_spi_rom_sched;

   localparam int GAP = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ch0_req = 1'b0, ch1_req = 1'b0;
   logic [23:0] ch0_addr = '0, ch1_addr = '0;
   logic [7:0]  ch0_len = '0, ch1_len = '0;
   logic        ch0_ack, ch0_done, ch1_ack, ch1_done;
   logic [7:0]  rd_data;
   logic        rd_valid, rd_ch, busy, spi_cs, spi_sclk, spi_mosi;
   logic        spi_miso = 1'b0;

   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;

   spi_rom_sched #(.SPI_CMD(8'h03), .GAP_CYCLES(GAP)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .ch0_req  (ch0_req),
      .ch0_addr (ch0_addr),
      .ch0_len  (ch0_len),
      .ch0_ack  (ch0_ack),
      .ch0_done (ch0_done),
      .ch1_req  (ch1_req),
      .ch1_addr (ch1_addr),
      .ch1_len  (ch1_len),
      .ch1_ack  (ch1_ack),
      .ch1_done (ch1_done),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rd_ch    (rd_ch),
      .busy     (busy),
      .spi_cs   (spi_cs),
      .spi_sclk (spi_sclk),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] rom_byte(input logic [23:0] a);
      if (a == 24'h000120) return 8'hA5;
      if (a == 24'h000121) return 8'h3C;
      return a[7:0] ^ a[15:8] ^ {a[4:0], a[23:21]} ^ 8'h5A;
   endfunction

   // Flash model: samples MOSI on spi_sclk rise, shifts data out on spi_sclk fall.
   logic [31:0] f_pre = '0;
   int          f_bits = 0;

   always @(negedge clk) begin
      if (!spi_cs) begin
         f_bits = 0;
      end else begin
         if (f_bits < 32) f_pre = {f_pre[30:0], spi_mosi};
         f_bits++;
      end
   end

   always @(posedge clk) begin
      logic [7:0] b;
      int d;
      #1;
      if (spi_cs && f_bits >= 32) begin
         d = f_bits - 32;
         b = rom_byte(f_pre[23:0] + 24'(d / 8));
         spi_miso = b[7 - (d % 8)];
      end else begin
         spi_miso = 1'($urandom_range(0, 1));
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic set_req(input bit ch, input logic v);
      if (ch) ch1_req = v;
      else ch0_req = v;
   endtask

   // One full transaction on channel ch, checking every pin each cycle.
   task automatic do_xfer(input bit ch, input logic [23:0] a, input logic [7:0] ln);
      int          L;
      int          nvalid;
      bit          found;
      logic [31:0] pre;
      logic        cs_e, mosi_e, v_e, done_e;
      L   = (ln == 8'd0) ? 256 : int'(ln);
      pre = {8'h03, a};
      nvalid = 0;
      @(posedge clk); #1;
      if (ch) begin ch1_addr = a; ch1_len = ln; end
      else begin ch0_addr = a; ch0_len = ln; end
      set_req(ch, 1'b1);
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (ch ? ch1_ack : ch0_ack) found = 1;
      end
      chk("ack_seen", 32'(found), 32'd1);
      if (!found) begin
         set_req(ch, 1'b0);
         return;
      end
      chk("grant_cycle", {busy, ch ? ch0_ack : ch1_ack}, 2'b00);
      for (int k = 1; k <= 32 + 8 * L + GAP; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin
            // Latched values must own the transaction.
            set_req(ch, 1'b0);
            if (ch) begin ch1_addr = 24'($urandom); ch1_len = 8'($urandom); end
            else begin ch0_addr = 24'($urandom); ch0_len = 8'($urandom); end
         end
         if (k == 10) set_req(!ch, 1'b1);
         if (k == 11) set_req(!ch, 1'b0);
         @(negedge clk);
         cs_e   = (k <= 32 + 8 * L);
         mosi_e = (k <= 32) ? pre[32 - k] : 1'b0;
         v_e    = (k >= 41) && (k <= 33 + 8 * L) && (((k - 41) % 8) == 0);
         done_e = (k == 33 + 8 * L);
         chk($sformatf("pins k=%0d", k),
             {spi_cs, busy, spi_mosi, rd_valid, ch0_done, ch1_done, ch0_ack, ch1_ack},
             {cs_e, 1'b1, mosi_e, v_e, done_e && !ch, done_e && ch, 2'b00});
         if (k == 33) chk("flash_preamble", f_pre, pre);
         if (v_e) begin
            chk($sformatf("rd_data n=%0d", nvalid), {rd_ch, rd_data},
                {ch, rom_byte(a + 24'(nvalid))});
            nvalid++;
         end
      end
      chk("byte_count", 32'(nvalid), 32'(L));
      @(negedge clk);
      chk("post_idle", {spi_cs, busy, spi_mosi, rd_valid, ch0_done, ch1_done, ch0_ack, ch1_ack},
          8'h00);
   endtask

   initial begin
      bit          found;
      bit          exp_ch;
      int          prev_g;
      logic        bad;
      logic [23:0] ra;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_pins", {spi_cs, busy, spi_mosi, rd_valid, ch0_done, ch1_done, ch0_ack, ch1_ack},
          8'h00);
      chk("reset_rd", {rd_ch, rd_data}, 9'h000);
      @(posedge clk); #1;
      reset_n = 1'b1;

      do_xfer(1'b0, 24'h000120, 8'd2);
      for (int t = 0; t < 6; t++) begin
         do_xfer(1'($urandom_range(0, 1)), 24'($urandom), 8'($urandom_range(1, 5)));
      end
      do_xfer(1'b1, 24'($urandom), 8'd0);

      // Reset during a channel 1 transfer.
      @(posedge clk); #1;
      ch1_addr = 24'($urandom);
      ch1_len  = 8'd4;
      ch1_req  = 1'b1;
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (ch1_ack) found = 1;
      end
      chk("rst_ack_seen", 32'(found), 32'd1);
      for (int k = 1; k <= 19; k++) begin
         @(posedge clk); #1;
         if (k == 1) ch1_req = 1'b0;
      end
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(negedge clk);
      chk("pre_reset_cs", {spi_cs, busy}, 2'b11);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      chk("post_reset_pins",
          {spi_cs, busy, spi_mosi, rd_valid, ch0_done, ch1_done, ch0_ack, ch1_ack}, 8'h00);
      chk("post_reset_rd", {rd_ch, rd_data}, 9'h000);
      bad = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         bad = bad | rd_valid | ch0_done | ch1_done | spi_cs | busy;
      end
      chk("post_reset_quiet", 32'(bad), 32'd0);

      // Both channels held: grants alternate starting with channel 0.
      @(posedge clk); #1;
      ra = 24'($urandom);
      ch0_addr = ra;
      ch1_addr = ra ^ 24'h800000;
      ch0_len  = 8'd1;
      ch1_len  = 8'd1;
      ch0_req  = 1'b1;
      ch1_req  = 1'b1;
      exp_ch   = 1'b0;
      prev_g   = 0;
      for (int gi = 0; gi < 4; gi++) begin
         found = 0;
         for (int i = 0; i < 200 && !found; i++) begin
            if (gi != 0 || i != 0) @(negedge clk);
            else @(negedge clk);
            if (ch0_ack || ch1_ack) found = 1;
         end
         chk($sformatf("rr_ack_seen %0d", gi), 32'(found), 32'd1);
         chk($sformatf("rr_winner %0d", gi), {ch1_ack, ch0_ack}, exp_ch ? 2'b10 : 2'b01);
         if (gi > 0) chk($sformatf("rr_spacing %0d", gi), 32'(cyc - prev_g), 32'(41 + GAP));
         prev_g = cyc;
         exp_ch = !exp_ch;
      end
      @(posedge clk); #1;
      ch0_req = 1'b0;
      ch1_req = 1'b0;
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (!busy) found = 1;
      end
      chk("final_idle", 32'(found), 32'd1);
      chk("final_acks", {ch0_ack, ch1_ack}, 2'b00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
